// File: rtl/hdc_im_sram_server_if.sv
// Read-request / response / host-load bus between the spatial encoder side and the item-memory server.
interface hdc_im_sram_server_if #(
    parameter int HV_DIM     = 2048,
    parameter int LOAD_WIDTH = 32
);
    logic [7:0]            ReqAddr_DI;
    logic [2:0]            ReqValid_SI;
    logic [2:0]            ReqReady_SO;
    logic [2:0]            RspValid_SO;
    logic [2:0]            RspReady_SI;
    logic [0:HV_DIM-1]     IMOut_mod3_D;
    logic [0:HV_DIM-1]     projM_mod3_neg;
    logic [0:HV_DIM-1]     projM_mod3_pos;
    logic                  LoadValid_SI;
    logic                  LoadReady_SO;
    logic [1:0]            LoadBank_DI;
    logic [7:0]            LoadAddr_DI;
    logic [LOAD_WIDTH-1:0] LoadWord_DI;
    logic                  LoadErr_SO;
    logic                  RspMiss_SO;

    modport slave (
        input  ReqAddr_DI, ReqValid_SI, RspReady_SI,
               LoadValid_SI, LoadBank_DI, LoadAddr_DI, LoadWord_DI,
        output ReqReady_SO, RspValid_SO, IMOut_mod3_D, projM_mod3_neg, projM_mod3_pos,
               LoadReady_SO, LoadErr_SO, RspMiss_SO
    );

    modport master (
        output ReqAddr_DI, ReqValid_SI, RspReady_SI,
               LoadValid_SI, LoadBank_DI, LoadAddr_DI, LoadWord_DI,
        input  ReqReady_SO, RspValid_SO, IMOut_mod3_D, projM_mod3_neg, projM_mod3_pos,
               LoadReady_SO, LoadErr_SO, RspMiss_SO
    );
endinterface

// File: rtl/hdc_im_sram_server.sv
// Three-bank hypervector row server (IM, projM_neg, projM_pos) with 1-cycle reads and a word-serial host load port.
// Optional HDC_IM_VALID_TRACK_EN: per-row written flags; unwritten reads return zero and set RspMiss_SO.
module hdc_im_sram_server #(
    parameter int HV_DIM     = 2048,
    parameter int DEPTH      = 256,
    parameter int LOAD_WIDTH = 32
) (
    input logic Clk_CI,
    input logic Reset_RI,
    hdc_im_sram_server_if.slave bus
);
    localparam int WORDS = HV_DIM / LOAD_WIDTH;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW    = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

    typedef enum logic {SERVE, LOAD} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        bank_q;
    logic [7:0]        addr_q;
    logic [0:HV_DIM-1] asm_q;
    logic [0:HV_DIM-1] row_next;
    logic              load_ready;
    logic              load_err;
    logic              rsp_miss;

    logic [2:0]        rsp_valid;
    logic [2:0]        req_ready;
    logic [2:0]        fire;
    logic [2:0]        miss_hit;
    logic [0:HV_DIM-1] rsp_data [3];

    logic              go_load;
    logic              word_acc;
    logic              last;
    logic              commit;
    logic [1:0]        wr_bank;
    logic [7:0]        wr_addr;
    logic [DW-1:0]     wbase;
    logic              rd_in_range;
    logic              wr_in_range;

    // Load wins a tie with pending requests: ready is withheld on the switch cycle.
    assign go_load  = (state == SERVE) && bus.LoadValid_SI && (rsp_valid == 3'b000) && !Reset_RI;
    assign fire     = bus.ReqValid_SI & req_ready;
    assign word_acc = load_ready && bus.LoadValid_SI;
    assign last     = (cnt == CW'(WORDS - 1));
    assign commit   = word_acc && last;
    assign wr_bank  = (cnt == '0) ? bus.LoadBank_DI : bank_q;
    assign wr_addr  = (cnt == '0) ? bus.LoadAddr_DI : addr_q;
    assign wbase    = DW'(cnt) * DW'(LOAD_WIDTH);

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            req_ready[b] = (state == SERVE) && !go_load && !Reset_RI &&
                           (!rsp_valid[b] || bus.RspReady_SI[b]);
        end
    end

    // Word k lands MSB-first at row index k*LOAD_WIDTH.
    always_comb begin
        row_next = asm_q;
        row_next[wbase +: LOAD_WIDTH] = bus.LoadWord_DI;
    end

    generate
        if (DEPTH >= 256) begin : g_full
            assign rd_in_range = 1'b1;
            assign wr_in_range = 1'b1;
        end else begin : g_part
            assign rd_in_range = bus.ReqAddr_DI < 8'(DEPTH);
            assign wr_in_range = wr_addr < 8'(DEPTH);
        end
    endgenerate

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state      <= SERVE;
            cnt        <= '0;
            load_ready <= 1'b0;
            load_err   <= 1'b0;
            rsp_miss   <= 1'b0;
        end else begin
            rsp_miss <= rsp_miss | (|miss_hit);
            if (state == SERVE) begin
                if (go_load) begin
                    state      <= LOAD;
                    load_ready <= 1'b1;
                end
            end else if (word_acc) begin
                asm_q <= row_next;
                if (cnt == '0) begin
                    bank_q <= bus.LoadBank_DI;
                    addr_q <= bus.LoadAddr_DI;
                end
                if (last) begin
                    cnt        <= '0;
                    state      <= SERVE;
                    load_ready <= 1'b0;
                    if (wr_bank == 2'd3) load_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_bank
        logic [0:HV_DIM-1] mem [DEPTH];
        logic [0:HV_DIM-1] rd_word;
        logic [0:HV_DIM-1] data_q;
        logic              valid_q;
        logic              rd_hit;
        logic              wr_en;

        assign wr_en = commit && (wr_bank == 2'(b)) && wr_in_range;

        always_ff @(posedge Clk_CI) begin
            if (!Reset_RI && wr_en) mem[wr_addr[MAW-1:0]] <= row_next;
        end

`ifdef HDC_IM_VALID_TRACK_EN
        logic [DEPTH-1:0] written;
        always_ff @(posedge Clk_CI) begin
            if (Reset_RI)   written <= '0;
            else if (wr_en) written[wr_addr[MAW-1:0]] <= 1'b1;
        end
        assign rd_hit      = rd_in_range && written[bus.ReqAddr_DI[MAW-1:0]];
        assign miss_hit[b] = fire[b] && rd_in_range && !written[bus.ReqAddr_DI[MAW-1:0]];
`else
        assign rd_hit      = rd_in_range;
        assign miss_hit[b] = 1'b0;
`endif

        assign rd_word = rd_hit ? mem[bus.ReqAddr_DI[MAW-1:0]] : '0;

        always_ff @(posedge Clk_CI) begin
            if (Reset_RI) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (fire[b]) begin
                valid_q <= 1'b1;
                data_q  <= rd_word;
            end else if (bus.RspReady_SI[b]) begin
                valid_q <= 1'b0;
            end
        end

        assign rsp_valid[b] = valid_q;
        assign rsp_data[b]  = data_q;
    end

    assign bus.ReqReady_SO    = req_ready;
    assign bus.RspValid_SO    = rsp_valid;
    assign bus.IMOut_mod3_D   = rsp_data[0];
    assign bus.projM_mod3_neg = rsp_data[1];
    assign bus.projM_mod3_pos = rsp_data[2];
    assign bus.LoadReady_SO   = load_ready;
    assign bus.LoadErr_SO     = load_err;
    assign bus.RspMiss_SO     = rsp_miss;
endmodule

// File: tb/tb_hdc_im_sram_server.sv
// Bench for hdc_im_sram_server: table-driven loads/reads with a per-bank response scoreboard plus handshake corner sequences.
module tb_hdc_im_sram_server;
    localparam int HV    = 2048;
    localparam int LW    = 32;
    localparam int WORDS = HV / LW;

    typedef struct {
        logic [1:0]  b;
        logic [7:0]  a;
        logic [31:0] base;
        logic [31:0] incr;
        bit          gaps;
    } ld_t;

    typedef struct {
        logic [2:0] m;
        logic [7:0] a;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdc_im_sram_server_if #(.HV_DIM(HV), .LOAD_WIDTH(LW)) bus ();
    hdc_im_sram_server #(.HV_DIM(HV), .DEPTH(256), .LOAD_WIDTH(LW)) dut (
        .Clk_CI(clk), .Reset_RI(rst), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [0:HV-1] model [int];
    logic [0:HV-1] sbq [3][$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic check_row(input string nm, input logic [0:HV-1] got, input logic [0:HV-1] exp);
        bit shown;
        total++;
        if (got !== exp) begin
            bad++;
            shown = 0;
            for (int k = 0; k < WORDS; k++) begin
                if (!shown && got[k*LW +: LW] !== exp[k*LW +: LW]) begin
                    $display("FAIL %s word%0d got=%h exp=%h", nm, k, got[k*LW +: LW], exp[k*LW +: LW]);
                    shown = 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] base, input logic [31:0] incr, input int k);
        return base + 32'(k) * incr;
    endfunction

    function automatic logic [0:HV-1] mk_row(input logic [31:0] base, input logic [31:0] incr);
        logic [0:HV-1] r;
        logic [31:0]   w;
        for (int k = 0; k < WORDS; k++) begin
            w = word_of(base, incr, k);
            for (int j = 0; j < LW; j++) r[k*LW + j] = w[LW-1-j];
        end
        return r;
    endfunction

    function automatic logic [0:HV-1] exp_row(input int b, input int a);
        int key;
        key = b * 256 + a;
        if (model.exists(key)) return model[key];
        return '0;
    endfunction

    function automatic logic [0:HV-1] rsp_of(input int b);
        if (b == 0) return bus.IMOut_mod3_D;
        if (b == 1) return bus.projM_mod3_neg;
        return bus.projM_mod3_pos;
    endfunction

    // Scoreboard: consume pops the oldest expected row, fire pushes a new one.
    always begin : mon
        logic [0:HV-1] e;
        @(negedge clk);
        #1;
        if (rst) begin
            for (int b = 0; b < 3; b++) sbq[b].delete();
`ifdef HDC_IM_VALID_TRACK_EN
            model.delete();
`endif
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (bus.RspValid_SO[b] && bus.RspReady_SI[b]) begin
                    if (sbq[b].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected bank=%0d", b);
                    end else begin
                        e = sbq[b].pop_front();
                        check_row($sformatf("rsp_bank%0d", b), rsp_of(b), e);
                    end
                end
                if (bus.ReqValid_SI[b] && bus.ReqReady_SO[b])
                    sbq[b].push_back(exp_row(b, int'(bus.ReqAddr_DI)));
            end
        end
    end

    task automatic load_row(input logic [1:0] b, input logic [7:0] a, input logic [31:0] base,
                            input logic [31:0] incr, input bit gaps);
        int guard;
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            bus.LoadValid_SI = 1'b1;
            bus.LoadBank_DI  = (k == 0) ? b : ~b;
            bus.LoadAddr_DI  = (k == 0) ? a : ~a;
            bus.LoadWord_DI  = word_of(base, incr, k);
            #1;
            guard = 0;
            while (!bus.LoadReady_SO && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (!bus.LoadReady_SO) begin
                total++;
                bad++;
                $display("FAIL load_timeout got=0 exp=1 word=%0d", k);
                bus.LoadValid_SI = 1'b0;
                return;
            end
            if (k == WORDS - 1) check("load_blocks_req", bus.ReqReady_SO, 3'b000);
            if (gaps && (k % 16) == 7) begin
                @(negedge clk);
                bus.LoadValid_SI = 1'b0;
            end
        end
        if (b != 2'd3) model[int'(b) * 256 + int'(a)] = mk_row(base, incr);
        @(negedge clk);
        bus.LoadValid_SI = 1'b0;
    endtask

    task automatic rd(input logic [2:0] m, input logic [7:0] a);
        @(negedge clk);
        bus.ReqValid_SI = m;
        bus.ReqAddr_DI  = a;
        bus.RspReady_SI = 3'b111;
        #1;
        check("rd_ready", bus.ReqReady_SO & m, m);
        @(negedge clk);
        bus.ReqValid_SI = 3'b000;
        #1;
        check("rd_valid", bus.RspValid_SO, m);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        ld_t lds [7];
        rd_t rds [7];
        logic [3:0] nib;

        lds[0] = '{2'd0, 8'h00, 32'h0000_0001, 32'h0000_0001, 1'b0};
        lds[1] = '{2'd1, 8'h10, 32'hDEAD_BEEF, 32'h0101_0101, 1'b1};
        lds[2] = '{2'd2, 8'h01, 32'h1234_5678, 32'h0000_0003, 1'b0};
        lds[3] = '{2'd2, 8'h02, 32'hFFFF_0000, 32'h0000_0005, 1'b0};
        lds[4] = '{2'd1, 8'hFF, 32'h8000_0001, 32'h0000_0007, 1'b1};
        lds[5] = '{2'd1, 8'h05, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0};
        lds[6] = '{2'd2, 8'h05, 32'h5A5A_5A5A, 32'h0000_0009, 1'b0};
        rds[0] = '{3'b001, 8'h00};
        rds[1] = '{3'b010, 8'h10};
        rds[2] = '{3'b100, 8'h01};
        rds[3] = '{3'b100, 8'h02};
        rds[4] = '{3'b010, 8'hFF};
        rds[5] = '{3'b111, 8'h05};
        rds[6] = '{3'b110, 8'h05};

        bus.ReqAddr_DI   = '0;
        bus.ReqValid_SI  = '0;
        bus.RspReady_SI  = '0;
        bus.LoadValid_SI = 1'b0;
        bus.LoadBank_DI  = '0;
        bus.LoadAddr_DI  = '0;
        bus.LoadWord_DI  = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", bus.ReqReady_SO, 3'b000);
        check("rst_rsp_valid", bus.RspValid_SO, 3'b000);
        check("rst_load_ready", bus.LoadReady_SO, 1'b0);
        check("rst_load_err", bus.LoadErr_SO, 1'b0);
        check("rst_miss", bus.RspMiss_SO, 1'b0);
        check("rst_data", {|bus.IMOut_mod3_D, |bus.projM_mod3_neg, |bus.projM_mod3_pos}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_serve_ready", bus.ReqReady_SO, 3'b111);
        check("idle_load_ready", bus.LoadReady_SO, 1'b0);

`ifdef HDC_IM_VALID_TRACK_EN
        rd(3'b010, 8'h10);
        check("miss_set", bus.RspMiss_SO, 1'b1);
`endif

        // Constant A5 row, then exact 1-cycle read latency.
        load_row(2'd0, 8'h05, 32'hA5A5_A5A5, 32'h0, 1'b0);
        @(negedge clk);
        bus.ReqValid_SI = 3'b001;
        bus.ReqAddr_DI  = 8'h05;
        bus.RspReady_SI = 3'b111;
        #1;
        check("a5_ready", bus.ReqReady_SO[0], 1'b1);
        check("a5_lat0", bus.RspValid_SO, 3'b000);
        @(negedge clk);
        bus.ReqValid_SI = 3'b000;
        #1;
        check("a5_lat1", bus.RspValid_SO, 3'b001);
        nib = bus.IMOut_mod3_D[0:3];
        check("a5_nibble", nib, 4'b1010);

        for (int i = 0; i < 7; i++) load_row(lds[i].b, lds[i].a, lds[i].base, lds[i].incr, lds[i].gaps);
        for (int i = 0; i < 7; i++) rd(rds[i].m, rds[i].a);

        // Backpressure on bank2: row1 held for 3 cycles, row2 queued behind it.
        @(negedge clk);
        bus.ReqValid_SI = 3'b100;
        bus.ReqAddr_DI  = 8'h01;
        bus.RspReady_SI = 3'b000;
        #1;
        check("bp_fire1", bus.ReqReady_SO[2], 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.ReqAddr_DI = 8'h02;
            #1;
            check("bp_hold_ready", bus.ReqReady_SO[2], 1'b0);
            check("bp_hold_valid", bus.RspValid_SO[2], 1'b1);
            check_row("bp_hold_data", bus.projM_mod3_pos, exp_row(2, 1));
        end
        @(negedge clk);
        bus.RspReady_SI = 3'b100;
        #1;
        check("bp_release", bus.ReqReady_SO[2], 1'b1);
        @(negedge clk);
        bus.ReqValid_SI = 3'b000;
        #1;
        check("bp_second_valid", bus.RspValid_SO[2], 1'b1);
        check_row("bp_second_data", bus.projM_mod3_pos, exp_row(2, 2));
        @(negedge clk);
        bus.RspReady_SI = 3'b000;
        #1;
        check("bp_drain", bus.RspValid_SO, 3'b000);

        // Load and reads collide: load wins, reads see the freshly committed row.
        @(negedge clk);
        bus.ReqValid_SI  = 3'b111;
        bus.ReqAddr_DI   = 8'h05;
        bus.RspReady_SI  = 3'b111;
        bus.LoadValid_SI = 1'b1;
        bus.LoadBank_DI  = 2'd0;
        bus.LoadAddr_DI  = 8'h05;
        bus.LoadWord_DI  = word_of(32'h3C3C_0001, 32'h0000_0101, 0);
        #1;
        check("collide_ready", bus.ReqReady_SO, 3'b000);
        load_row(2'd0, 8'h05, 32'h3C3C_0001, 32'h0000_0101, 1'b0);
        #1;
        check("post_commit_ready", bus.ReqReady_SO, 3'b111);
        check("post_commit_lready", bus.LoadReady_SO, 1'b0);
        @(negedge clk);
        bus.ReqValid_SI = 3'b000;
        #1;
        check("post_commit_valid", bus.RspValid_SO, 3'b111);

        // Bank 3 load is swallowed.
        load_row(2'd3, 8'h05, 32'hCAFE_F00D, 32'h0000_0011, 1'b1);
        #1;
        check("bad_bank_err", bus.LoadErr_SO, 1'b1);
        rd(3'b111, 8'h05);

        // Reset while a response is held.
        @(negedge clk);
        bus.ReqValid_SI = 3'b001;
        bus.ReqAddr_DI  = 8'h05;
        bus.RspReady_SI = 3'b000;
        @(negedge clk);
        bus.ReqValid_SI = 3'b000;
        #1;
        check("pre_rst_hold", bus.RspValid_SO, 3'b001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rsp_lost", bus.RspValid_SO, 3'b000);
        check("rst_err_clear", bus.LoadErr_SO, 1'b0);

        // Reset mid-load: partial row must not reach memory.
        @(negedge clk);
        bus.LoadValid_SI = 1'b1;
        bus.LoadBank_DI  = 2'd0;
        bus.LoadAddr_DI  = 8'h00;
        bus.LoadWord_DI  = 32'h7777_7777;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        bus.LoadValid_SI = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_load_abort", bus.LoadReady_SO, 1'b0);
        check("rst_load_serve", bus.ReqReady_SO, 3'b111);
        rd(3'b001, 8'h00);

        @(negedge clk);
        #1;
`ifdef HDC_IM_VALID_TRACK_EN
        check("miss_final", bus.RspMiss_SO, 1'b1);
`else
        check("miss_tied", bus.RspMiss_SO, 1'b0);
`endif
        check("sb_empty", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hdc_im_sram_server.md
Name: hdc_im_sram_server

Overview:
- Responder side of the item-memory / projection-memory read interface used by the spatial encoder (addr + per-bank ready/valid request, HV-wide data return).
- Holds three banks of hypervector rows: IM, projM_neg, projM_pos.
- A host load port writes rows word-by-word.
- Read requests return one full HV row per bank after a fixed 1-cycle latency.
- Sits beside the spatial encoder in the top level, replacing the external SRAM models.

Parameters:
- HV_DIM, 2048, hypervector width in bits; must be a multiple of LOAD_WIDTH.
- DEPTH, 256, rows per bank; address width is 8 (clog2(DEPTH)).
- LOAD_WIDTH, 32, load-port word width.
- Derived: WORDS = HV_DIM/LOAD_WIDTH (64 with defaults).

Ports:
- Clk_CI  in  1  clock; all logic on rising edge.
- Reset_RI  in  1  synchronous, active-high reset.
- ReqAddr_DI  in  8  row address, shared by all banks.
- ReqValid_SI  in  3  per-bank read request; bit0 IM, bit1 projM_neg, bit2 projM_pos.
- ReqReady_SO  out  3  per-bank request accept.
- RspValid_SO  out  3  per-bank response valid.
- RspReady_SI  in  3  per-bank response accept.
- IMOut_mod3_D  out  [0:HV_DIM-1]  bank0 read data.
- projM_mod3_neg  out  [0:HV_DIM-1]  bank1 read data.
- projM_mod3_pos  out  [0:HV_DIM-1]  bank2 read data.
- LoadValid_SI  in  1  load word valid.
- LoadReady_SO  out  1  load word accept.
- LoadBank_DI  in  2  target bank; sampled on the first word of a row.
- LoadAddr_DI  in  8  target row; sampled on the first word of a row.
- LoadWord_DI  in  LOAD_WIDTH  load data.
- LoadErr_SO  out  1  sticky: row loaded to bank 3 was discarded.
- RspMiss_SO  out  1  sticky: read of an unwritten row (optional feature only; otherwise 0).

Behaviour:
- Reset values: RspValid_SO=0, ReqReady_SO=0, LoadReady_SO=0, LoadErr_SO=0, RspMiss_SO=0, all data outputs 0, FSM=SERVE, word counter=0. Memory contents are not reset.
- FSM states: SERVE, LOAD.
- SERVE:
  - Per bank b: ReqReady_SO[b] = ~RspValid_SO[b] | RspReady_SI[b], gated low on the cycle SERVE->LOAD is taken.
  - A request fires when ReqValid[b] & ReqReady[b]. On the next edge the data register for bank b <= mem_b[ReqAddr_DI] and RspValid[b] <= 1. Latency is exactly 1 cycle.
  - The response holds its data and RspValid stable until RspReady is seen. A fire and a consume in the same cycle give back-to-back throughput of 1 row/cycle/bank.
  - Banks are independent. Several banks may fire in the same cycle with the same address.
- SERVE->LOAD: taken when LoadValid_SI=1 and RspValid_SO==3'b000 and no request fires that cycle. Load wins a tie, because ReqReady is forced low that cycle. LoadReady_SO=1 from the cycle after entry.
- LOAD:
  - ReqReady_SO=0 and LoadReady_SO=1.
  - Each accepted word k (0..WORDS-1) maps LoadWord_DI[LOAD_WIDTH-1-j] into assembly-register bit k*LOAD_WIDTH+j (MSB first into index 0).
  - Bank and address are latched at k=0.
  - At k=WORDS-1: the row is committed to mem[bank][addr] on that edge, the counter returns to 0, and the FSM goes to SERVE.
  - Bank 3: words are consumed, nothing is written, and LoadErr_SO is set (cleared only by reset).
  - Gaps in LoadValid are allowed. The counter holds during gaps.
- Read-after-load: a read in the first SERVE cycle after commit returns the new row.
- Reset mid-load: the partial row is discarded with no write, and the FSM returns to SERVE.
- Reset mid-response: RspValid drops to 0 and the response is lost.
- Address >= DEPTH cannot occur with 8 bits at default. For smaller DEPTH, out-of-range addresses read as zero and writes to them are dropped.

Optional Feature:
- Macro: HDC_IM_VALID_TRACK_EN.
- Defined:
  - Per-bank, per-row written flag (3xDEPTH flops), cleared on reset and set on commit.
  - A read of an unwritten row returns all zeros with normal handshake timing and sets the sticky RspMiss_SO.
- Undefined:
  - No flags. A read returns raw memory contents (X in simulation if never written).
  - RspMiss_SO is tied 0.

Test Plan:
- Reset: hold Reset_RI 2 cycles, then release with all inputs idle -> all outputs 0, FSM=SERVE.
- Load then read:
  - Load bank0 addr 0x05 with 64 words 32'hA5A5A5A5, then ReqValid=3'b001 addr 0x05 with RspReady=1.
  - -> RspValid[0]=1 exactly 1 cycle later; IMOut bits [0:3] = 1010; whole row = repeating A5.
- Backpressure:
  - Two back-to-back requests on bank2, addrs 1 then 2, RspReady low for 3 cycles.
  - -> ReqReady[2]=0 while the first response is held; data stays row1; after RspReady=1 rows 1 and 2 return in order with no loss.
- Collision:
  - LoadValid=1 and ReqValid=3'b111 in the same SERVE cycle with no pending responses.
  - -> ReqReady=000 that cycle, LOAD entered; reads are served after the 64th word commits.
- Bad bank: load a row with LoadBank_DI=3 -> 64 words accepted, LoadErr_SO=1, banks 0-2 unchanged.
- With HDC_IM_VALID_TRACK_EN: after reset, read bank1 addr 0x10 -> projM_mod3_neg all 0, RspMiss_SO=1. Without the macro: RspMiss_SO stays 0.
